reliable_nand_pipeline: RTL and testbench

//  Von Neumann multiplexed NAND over N-wire bundles: one executive stage plus STAGES restorative stages,

---
 rtl/reliable_nand_pipeline.sv | 142 ++++++++++++++
 tb/tb_reliable_nand_pipeline.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reliable_nand_pipeline.sv
// reliable_nand_pipeline
//   Von Neumann multiplexed NAND over N-wire bundles. Stage 0 (executive)
//   NANDs bundle X with bundle Y. Each of the STAGES restorative stages NANDs
//   the previous bundle with a copy of itself rotated by the stage index.
//   Every stage is registered and carries a valid bit. A single global
//   advance signal moves the whole pipeline, so bubbles are kept in place.
//   Each wire of each stage has its own 16-bit Galois LFSR. When err_en_i is
//   set, that LFSR can flip the wire's output.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   valid_i / ready_o   input handshake; x_i, y_i are the input bundles
//   err_en_i            runtime enable for fault injection
//   valid_o / ready_i   output handshake; z_o is the registered output bundle
//   count_o             popcount of z_o
//   bit_o               decoded logic value (count_o >= HI_THRESH)
//   ambiguous_o         LO_THRESH < count_o < HI_THRESH
//   flips_o             saturating count of flips injected into valid data
module reliable_nand_pipeline #(
    parameter int          N                 = 10,
    parameter int          STAGES            = 2,
    parameter int          ERROR_PROBABILITY = 0,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1,
    parameter int          HI_THRESH         = N * 9 / 10,
    parameter int          LO_THRESH         = N / 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [N-1:0]             x_i,
    input  logic [N-1:0]             y_i,
    input  logic                     err_en_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [N-1:0]             z_o,
    output logic [$clog2(N+1)-1:0]   count_o,
    output logic                     bit_o,
    output logic                     ambiguous_o,
    output logic [31:0]              flips_o
);

    localparam int         CW  = $clog2(N + 1);
    // One bit wider than the LFSR byte, so that 256 means "always flip".
    localparam logic [8:0] EP9 = 9'(ERROR_PROBABILITY);

    // Galois form of x^16+x^14+x^13+x^11+1 (right shift, toggle mask 0xB400).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [31:0] popcount(input logic [N-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + 32'(v[i]);
        return c;
    endfunction

    logic [STAGES:0][N-1:0]       data_q, data_d, stage_out;
    logic [STAGES:0]              vld_q, vld_d, stage_vld;
    logic [STAGES:0][N-1:0][15:0] lfsr_q, lfsr_d, lfsr_nxt, seed;
    logic [31:0]                  flips_q, flips_d;
    logic [STAGES+1:0][31:0]      flip_acc;
    logic [32:0]                  flip_sum;
    logic [31:0]                  z_cnt;
    logic                         adv;

    // One global advance: when the output is blocked, nothing moves, not even the LFSRs.
    assign adv = ready_i | ~vld_q[STAGES];

    assign flip_acc[0] = '0;

    for (genvar k = 0; k <= STAGES; k++) begin : g_stage
        logic [N-1:0] a, b, f;
        logic         in_vld;

        if (k == 0) begin : g_exec
            assign a      = x_i;
            assign b      = y_i;
            assign in_vld = valid_i;
        end else begin : g_rest
            assign a      = data_q[k-1];
            assign in_vld = vld_q[k-1];
            // Stage k pairs each wire with the wire k places further on.
            for (genvar i = 0; i < N; i++) begin : g_rot
                assign b[i] = data_q[k-1][(i + k) % N];
            end
        end

        for (genvar i = 0; i < N; i++) begin : g_wire
            localparam logic [15:0] RAW = LFSR_SEED ^ 16'(k * N + i + 1);
            // An all-zero seed would lock the LFSR, so fall back to the base seed.
            assign seed[k][i]     = (RAW == 16'h0000) ? LFSR_SEED : RAW;
            assign f[i]           = err_en_i & ({1'b0, lfsr_q[k][i][7:0]} < EP9);
            assign lfsr_nxt[k][i] = lfsr_step(lfsr_q[k][i]);
        end

        assign stage_out[k]  = ~(a & b) ^ f;
        assign stage_vld[k]  = in_vld;
        // Flips into bubbles are real hardware events, but they are not counted.
        assign flip_acc[k+1] = flip_acc[k] + (in_vld ? popcount(f) : 32'd0);
    end

    assign flip_sum = {1'b0, flips_q} + {1'b0, flip_acc[STAGES+1]};

    always_comb begin
        data_d  = data_q;
        vld_d   = vld_q;
        lfsr_d  = lfsr_q;
        flips_d = flips_q;
        if (adv) begin
            data_d  = stage_out;
            vld_d   = stage_vld;
            lfsr_d  = lfsr_nxt;
            flips_d = flip_sum[32] ? 32'hFFFF_FFFF : flip_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            vld_q   <= '0;
            lfsr_q  <= seed;
            flips_q <= '0;
        end else begin
            data_q  <= data_d;
            vld_q   <= vld_d;
            lfsr_q  <= lfsr_d;
            flips_q <= flips_d;
        end
    end

    assign ready_o     = adv;
    assign valid_o     = vld_q[STAGES];
    assign z_o         = data_q[STAGES];
    assign flips_o     = flips_q;
    assign z_cnt       = popcount(data_q[STAGES]);
    assign count_o     = CW'(z_cnt);
    assign bit_o       = (z_cnt >= 32'(HI_THRESH));
    assign ambiguous_o = (z_cnt > 32'(LO_THRESH)) && (z_cnt < 32'(HI_THRESH));

endmodule

// File: tb/tb_reliable_nand_pipeline.sv
module tb_reliable_nand_pipeline;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- A: defaults (N=10, STAGES=2, EP=0), scoreboard-checked
    logic       va, ra, ready_a, valid_a, bit_a, amb_a;
    logic [9:0] xa, ya, z_a;
    logic [3:0] cnt_a;
    logic [31:0] fl_a;
    reliable_nand_pipeline dut_a (
        .clk(clk), .reset_n(reset_n), .valid_i(va), .ready_o(ready_a), .x_i(xa), .y_i(ya),
        .err_en_i(1'b0), .valid_o(valid_a), .ready_i(ra), .z_o(z_a), .count_o(cnt_a),
        .bit_o(bit_a), .ambiguous_o(amb_a), .flips_o(fl_a));

    // ---------------- shared single-beat stimulus for B, C, D (ready_i tied high)
    logic       vs, err_c;
    logic [9:0] xs, ys;

    logic       rdy_b, val_b, bit_b, amb_b;
    logic [3:0] z_b;
    logic [2:0] cnt_b;
    logic [31:0] fl_b;
    reliable_nand_pipeline #(.N(4), .STAGES(2), .HI_THRESH(3), .LO_THRESH(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .valid_i(vs), .ready_o(rdy_b), .x_i(xs[3:0]), .y_i(ys[3:0]),
        .err_en_i(1'b0), .valid_o(val_b), .ready_i(1'b1), .z_o(z_b), .count_o(cnt_b),
        .bit_o(bit_b), .ambiguous_o(amb_b), .flips_o(fl_b));

    logic       rdy_c, val_c, bit_c, amb_c;
    logic [9:0] z_c;
    logic [3:0] cnt_c;
    logic [31:0] fl_c;
    reliable_nand_pipeline #(.N(10), .STAGES(2), .ERROR_PROBABILITY(256)) dut_c (
        .clk(clk), .reset_n(reset_n), .valid_i(vs), .ready_o(rdy_c), .x_i(xs), .y_i(ys),
        .err_en_i(err_c), .valid_o(val_c), .ready_i(1'b1), .z_o(z_c), .count_o(cnt_c),
        .bit_o(bit_c), .ambiguous_o(amb_c), .flips_o(fl_c));

    logic       rdy_d, val_d, bit_d, amb_d;
    logic [9:0] z_d;
    logic [3:0] cnt_d;
    logic [31:0] fl_d;
    reliable_nand_pipeline #(.N(10), .STAGES(1)) dut_d (
        .clk(clk), .reset_n(reset_n), .valid_i(vs), .ready_o(rdy_d), .x_i(xs), .y_i(ys),
        .err_en_i(1'b0), .valid_o(val_d), .ready_i(1'b1), .z_o(z_d), .count_o(cnt_d),
        .bit_o(bit_d), .ambiguous_o(amb_d), .flips_o(fl_d));

    // ---------------- E: N=2, STAGES=0, EP=128, always-valid input, random backpressure
    logic       re, rdy_e, val_e, bit_e, amb_e;
    logic [1:0] z_e, cnt_e;
    logic [31:0] fl_e;
    reliable_nand_pipeline #(.N(2), .STAGES(0), .ERROR_PROBABILITY(128)) dut_e (
        .clk(clk), .reset_n(reset_n), .valid_i(1'b1), .ready_o(rdy_e), .x_i(2'b00), .y_i(2'b00),
        .err_en_i(1'b1), .valid_o(val_e), .ready_i(re), .z_o(z_e), .count_o(cnt_e),
        .bit_o(bit_e), .ambiguous_o(amb_e), .flips_o(fl_e));

    // ---------------- reference models
    function automatic logic [9:0] model_a(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] s, b;
        s = ~(x & y);
        for (int k = 1; k <= 2; k++) begin
            for (int i = 0; i < 10; i++) b[i] = s[(i + k) % 10];
            s = ~(s & b);
        end
        return s;
    endfunction

    function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    logic [9:0] sb[$];

    // An item is accepted on the edge after a cycle with valid & ready; record it now.
    always @(negedge clk)
        if (reset_n && va && ready_a) sb.push_back(model_a(xa, ya));

    always @(negedge clk)
        if (reset_n && valid_a && ra) begin
            if (sb.size() == 0) chk("a_unexpected_output", 32'(z_a), 32'h0DEAD);
            else chk("a_z", 32'(z_a), 32'(sb.pop_front()));
        end

    // Model for E: stage 0 only; x=y=0 so the NAND output is 1, and each wire
    // is inverted by its own LFSR whenever the low byte is below 128.
    logic [15:0] ml0, ml1;
    logic [1:0]  mz;
    logic        mv, mok = 1'b0, mf0, mf1;
    logic [31:0] mfl;
    always @(posedge clk) begin
        if (!reset_n) begin
            ml0 = 16'hACE0; ml1 = 16'hACE3; mz = 2'b00; mv = 1'b0; mfl = 0; mok = 1'b1;
        end else if (re | ~mv) begin
            mf0 = (ml0[7:0] < 8'd128);
            mf1 = (ml1[7:0] < 8'd128);
            mz  = {~mf1, ~mf0};
            mv  = 1'b1;
            mfl = mfl + 32'(mf0) + 32'(mf1);
            ml0 = lfsr_ref(ml0);
            ml1 = lfsr_ref(ml1);
        end
    end

    always @(negedge clk)
        if (reset_n && mok) begin
            chk("e_valid", 32'(val_e), 32'(mv));
            chk("e_z", 32'(z_e), 32'(mz));
            chk("e_flips", fl_e, mfl);
        end

    always @(posedge clk) begin
        #1;
        re = ($urandom_range(0, 3) != 0);
    end

    // ---------------- drivers
    task automatic send_a(input logic [9:0] x, input logic [9:0] y);
        logic acc;
        int   t;
        va = 1'b1; xa = x; ya = y;
        t = 0;
        do begin
            @(negedge clk);
            acc = ready_a;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 20);
        if (!acc) chk("a_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_s(input logic [9:0] x, input logic [9:0] y);
        vs = 1'b1; xs = x; ys = y;
        @(posedge clk); #1;
        vs = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; va = 1'b0; ra = 1'b1; xa = '0; ya = '0;
        vs = 1'b0; xs = '0; ys = '0; err_c = 1'b1; re = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_z", 32'(z_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_ready", 32'(ready_a), 1);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_bit", 32'(bit_a), 0);
        chk("rst_amb", 32'(amb_a), 0);
        chk("rst_flips", fl_a, 0);
        @(posedge clk); #1;

        // single beat latency: x=y=all-ones gives z=0 after 3 stages
        send_a(10'h3FF, 10'h3FF);
        va = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("lat_not_yet", 32'(valid_a), 0);
        @(posedge clk); @(negedge clk);
        chk("lat_valid", 32'(valid_a), 1);
        chk("lat_z", 32'(z_a), 0);
        chk("lat_count", 32'(cnt_a), 0);
        chk("lat_bit", 32'(bit_a), 0);
        @(posedge clk); #1;

        // back-to-back random stream
        for (int i = 0; i < 6; i++) send_a(10'($urandom), 10'($urandom));
        va = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // backpressure: 8 beats, ready_i low for 4 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) send_a(10'($urandom), 10'($urandom));
                va = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 ra = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_ready", 32'(ready_a), 0);
                    chk("stall_valid", 32'(valid_a), 1);
                    if (sb.size() > 0) chk("stall_z_held", 32'(z_a), 32'(sb[0]));
                    else chk("stall_sb_empty", 32'(sb.size()), 1);
                    @(posedge clk); #1;
                end
                ra = 1'b1;
            end
        join
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb.size()), 0);

        // B/C/D: x=y=all-ones
        send_s(10'h3FF, 10'h3FF);
        @(posedge clk); @(negedge clk);
        chk("d_valid", 32'(val_d), 1);
        chk("d_z_and", 32'(z_d), 32'h3FF);
        chk("d_bit", 32'(bit_d), 1);
        chk("d_flips", fl_d, 0);
        @(posedge clk); @(negedge clk);
        chk("c_valid", 32'(val_c), 1);
        chk("c_z_allflip", 32'(z_c), 32'h3FF);
        chk("c_flips_30", fl_c, 30);
        chk("b_z_ones", 32'(z_b), 0);
        @(posedge clk); #1;

        // B: x=1111, y=0011 -> 0101, ambiguous
        send_s(10'h00F, 10'h003);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("b_valid", 32'(val_b), 1);
        chk("b_z", 32'(z_b), 32'h5);
        chk("b_count", 32'(cnt_b), 2);
        chk("b_amb", 32'(amb_b), 1);
        chk("b_bit", 32'(bit_b), 0);
        chk("c_flips_60", fl_c, 60);
        @(posedge clk); #1;

        // C with injection disabled: clean NAND result, counter frozen
        err_c = 1'b0;
        send_s(10'h3FF, 10'h3FF);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("c_noerr_valid", 32'(val_c), 1);
        chk("c_noerr_z", 32'(z_c), 0);
        chk("c_noerr_flips", fl_c, 60);
        @(posedge clk); #1;

        // reset mid-stream with two beats in flight in A and C
        err_c = 1'b1;
        va = 1'b1; vs = 1'b1; xa = 10'h155; ya = 10'h2AA; xs = 10'h3FF; ys = 10'h3FF;
        @(posedge clk); #1;
        xa = 10'h0F0;
        @(posedge clk); #1;
        va = 1'b0; vs = 1'b0;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid_a", 32'(valid_a), 0);
        chk("mid_rst_z_a", 32'(z_a), 0);
        chk("mid_rst_valid_c", 32'(val_c), 0);
        chk("mid_rst_flips_c", fl_c, 0);
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            chk("mid_rst_no_emerge_a", 32'(valid_a), 0);
            chk("mid_rst_no_emerge_c", 32'(val_c), 0);
        end
        chk("mid_rst_flips_c_hold", fl_c, 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
